// File: rtl/memcheck.sv
// memcheck: scans n words from base m on the memory_controller read port and counts words whose
// low CMP_W bits equal c. Optional feature macro: MEMCHECK_EARLY_EXIT_EN (stop at first mismatch).
`ifndef MEMORY_CONTROLLER_ADDR_SIZE
`define MEMORY_CONTROLLER_ADDR_SIZE 32
`endif
`ifndef MEMORY_CONTROLLER_DATA_SIZE
`define MEMORY_CONTROLLER_DATA_SIZE 32
`endif

module memcheck #(
  parameter int unsigned ADDR_W = `MEMORY_CONTROLLER_ADDR_SIZE,
  parameter int unsigned DATA_W = `MEMORY_CONTROLLER_DATA_SIZE,
  parameter int unsigned CMP_W  = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] m,
  input  logic [31:0]       c,
  input  logic [31:0]       n,
  output logic              finish,
  output logic [31:0]       return_val,
  output logic [ADDR_W-1:0] first_bad,
  output logic [ADDR_W-1:0] memory_controller_address,
  output logic              memory_controller_write_enable,
  output logic [DATA_W-1:0] memory_controller_in,
  input  logic [DATA_W-1:0] memory_controller_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_m;
  logic [CMP_W-1:0]  r_c;
  logic [31:0]       r_n;
  logic [31:0]       r_issued;
  logic [RD_LAT-1:0] r_vpipe;
  logic [ADDR_W-1:0] r_apipe [RD_LAT];

  logic              w_push;
  logic              w_tail_v;
  logic [ADDR_W-1:0] w_tail_addr;
  logic              w_match;
  logic              w_kill;
  logic              w_drained;
  logic [RD_LAT-1:0] w_vpipe_next;
  logic              w_unused;

  // This block only reads; the write side of the shared port is held idle.
  assign memory_controller_write_enable = 1'b0;
  assign memory_controller_in           = '0;

  // Bit 0 of the valid pipe is the newest read, bit RD_LAT-1 lines up with returning data.
  assign w_push       = (r_state == S_ISSUE);
  assign w_vpipe_next = RD_LAT'({r_vpipe, w_push});
  assign w_drained    = (RD_LAT'({r_vpipe, 1'b0}) == '0);
  assign w_tail_v     = r_vpipe[RD_LAT-1];
  assign w_tail_addr  = r_apipe[RD_LAT-1];
  assign w_match      = (memory_controller_out[CMP_W-1:0] == r_c);

`ifdef MEMCHECK_EARLY_EXIT_EN
  assign w_kill = w_tail_v & ~w_match;
`else
  assign w_kill = 1'b0;
`endif

  assign w_unused = ^{c[31:CMP_W], memory_controller_out[DATA_W-1:CMP_W]};

  // Address pipe travels alongside the valid pipe so a mismatch can be blamed on its address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(RD_LAT); i++) r_apipe[i] <= '0;
    end else begin
      r_apipe[0] <= memory_controller_address;
      for (int i = 1; i < int'(RD_LAT); i++) r_apipe[i] <= r_apipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state                   <= S_IDLE;
      r_m                       <= '0;
      r_c                       <= '0;
      r_n                       <= '0;
      r_issued                  <= '0;
      r_vpipe                   <= '0;
      finish                    <= 1'b0;
      return_val                <= '0;
      first_bad                 <= '1;
      memory_controller_address <= '0;
    end else begin
      finish  <= 1'b0;
      r_vpipe <= w_vpipe_next;

      if (w_tail_v) begin
        if (w_match) begin
          return_val <= return_val + 32'd1;
        end else if (first_bad == '1) begin
          first_bad <= w_tail_addr;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m        <= m;
            r_c        <= c[CMP_W-1:0];
            r_n        <= n;
            r_issued   <= '0;
            return_val <= '0;
            first_bad  <= '1;
            r_state    <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (r_n == 32'd0) begin
            finish  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            memory_controller_address <= r_m;
            r_issued                  <= 32'd1;
            r_state                   <= S_ISSUE;
          end
        end
        // The address on the bus this cycle is read number r_issued.
        S_ISSUE: begin
          if (w_kill || (r_issued == r_n)) begin
            r_state <= S_DRAIN;
          end else begin
            memory_controller_address <= r_m + ADDR_W'(r_issued);
            r_issued                  <= r_issued + 32'd1;
          end
        end
        S_DRAIN: begin
          if (w_kill || w_drained) begin
            finish  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Reads still in flight after an early-exit mismatch are dropped.
      if (w_kill) r_vpipe <= '0;
    end
  end

endmodule

// File: tb/tb_memcheck.sv
// tb_memcheck: directed checks of memcheck against a behavioural RAM shared by a RD_LAT=1
// instance and a RD_LAT=3 instance, both with a 5-bit address bus.
`timescale 1ns/1ps
module tb_memcheck;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_a, start_b;
  logic [AW-1:0] m;
  logic [31:0]   c, n;
  logic          fin_a, fin_b, we_a, we_b;
  logic [31:0]   rv_a, rv_b;
  logic [AW-1:0] fb_a, fb_b, addr_a, addr_b;
  logic [DW-1:0] din_a, din_b, dout_a, dout_b;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] pipe_b [3];
  logic [AW-1:0] addr_q [$];

  int errors = 0;
  int checks = 0;
  bit we_seen = 1'b0;

  int            lat;
  logic [31:0]   rv;
  logic [AW-1:0] fb;
  bit            fin_seen;
  logic [AW-1:0] wrap_exp [4];

  always #5 clk = ~clk;

  memcheck #(.ADDR_W(AW), .DATA_W(DW), .CMP_W(8), .RD_LAT(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .m(m), .c(c), .n(n),
    .finish(fin_a), .return_val(rv_a), .first_bad(fb_a),
    .memory_controller_address(addr_a), .memory_controller_write_enable(we_a),
    .memory_controller_in(din_a), .memory_controller_out(dout_a)
  );

  memcheck #(.ADDR_W(AW), .DATA_W(DW), .CMP_W(8), .RD_LAT(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .m(m), .c(c), .n(n),
    .finish(fin_b), .return_val(rv_b), .first_bad(fb_b),
    .memory_controller_address(addr_b), .memory_controller_write_enable(we_b),
    .memory_controller_in(din_b), .memory_controller_out(dout_b)
  );

  // RAM read ports with 1 and 3 cycles of latency.
  always @(posedge clk) dout_a <= mem[addr_a];
  always @(posedge clk) begin
    pipe_b[0] <= mem[addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign dout_b = pipe_b[2];

  always @(negedge clk) begin
    if (we_a !== 1'b0 || we_b !== 1'b0 || din_a !== '0 || din_b !== '0) we_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start a scan; lat counts cycles after the start cycle until finish is seen (-1 on timeout).
  task automatic scan(input bit sel, input logic [AW-1:0] mm, input logic [31:0] cc,
                      input logic [31:0] nn, input int pulse_at,
                      output int lat_o, output logic [31:0] rv_o, output logic [AW-1:0] fb_o);
    bit done;
    @(negedge clk);
    m = mm; c = cc; n = nn;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    lat_o = 1;
    done  = 1'b0;
    addr_q.delete();
    while (!done && lat_o < 400) begin
      if (lat_o == pulse_at) begin
        m = 5'd20; n = 32'd3; c = 32'h0;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      if (lat_o >= 2 && lat_o <= int'(nn) + 1) addr_q.push_back(sel ? addr_b : addr_a);
      if ((sel ? fin_b : fin_a) === 1'b1) done = 1'b1;
      else begin
        @(negedge clk);
        lat_o++;
      end
    end
    start_a = 1'b0; start_b = 1'b0;
    if (!done) lat_o = -1;
    rv_o = sel ? rv_b : rv_a;
    fb_o = sel ? fb_b : fb_a;
  endtask

  initial begin
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    m = '0; c = '0; n = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    wrap_exp[0] = 5'd30; wrap_exp[1] = 5'd31; wrap_exp[2] = 5'd0; wrap_exp[3] = 5'd1;

    repeat (2) @(negedge clk);
    chk("rst_finish", 32'(fin_a), 32'h0);
    chk("rst_rv", rv_a, 32'h0);
    chk("rst_first_bad", 32'(fb_a), 32'h1F);
    chk("rst_addr", 32'(addr_a), 32'h0);
    chk("rst_finish_b", 32'(fin_b), 32'h0);
    reset = 1'b1;

    // Fill check
    for (int i = 0; i < 8; i++) mem[i] = 32'h0000_00A5;
    scan(1'b0, 5'd0, 32'hA5, 32'd8, 0, lat, rv, fb);
    chk("fill_latency", 32'(lat), 32'd11);
    chk("fill_rv", rv, 32'd8);
    chk("fill_first_bad", 32'(fb), 32'h1F);
    @(negedge clk);
    chk("fill_finish_one_cycle", 32'(fin_a), 32'h0);
    chk("fill_addr_hold", 32'(addr_a), 32'd7);
    repeat (3) @(negedge clk);
    chk("fill_rv_hold", rv_a, 32'd8);

    // Zero count
    scan(1'b0, 5'd3, 32'hA5, 32'd0, 0, lat, rv, fb);
    chk("zero_latency", 32'(lat), 32'd2);
    chk("zero_rv", rv, 32'd0);
    chk("zero_first_bad", 32'(fb), 32'h1F);
    chk("zero_addr_unchanged", 32'(addr_a), 32'd7);

    // Single corruption; upper data bits and upper c bits are ignored
    for (int i = 0; i < 8; i++) mem[i] = {24'(i + 1), 8'h3C};
    mem[5] = 32'h0000_3C00;
    scan(1'b0, 5'd0, 32'h7777_773C, 32'd8, 0, lat, rv, fb);
`ifdef MEMCHECK_EARLY_EXIT_EN
    chk("corrupt_latency", 32'(lat), 32'd10);
    chk("corrupt_rv", rv, 32'd5);
`else
    chk("corrupt_latency", 32'(lat), 32'd11);
    chk("corrupt_rv", rv, 32'd7);
`endif
    chk("corrupt_first_bad", 32'(fb), 32'd5);

    // Address wrap 30, 31, 0, 1
    mem[29] = 32'h11; mem[30] = 32'h11; mem[31] = 32'h11;
    mem[0]  = 32'h11; mem[1]  = 32'h22; mem[2]  = 32'h11;
    scan(1'b0, 5'd30, 32'h11, 32'd4, 0, lat, rv, fb);
    chk("wrap_latency", 32'(lat), 32'd7);
    chk("wrap_rv", rv, 32'd3);
    chk("wrap_first_bad", 32'(fb), 32'd1);
    chk("wrap_addr_count", 32'(addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("wrap_addr_seq", 32'(addr_q[i]), 32'(wrap_exp[i]));

    // Start pulsed mid-scan is ignored
    for (int i = 0; i < 16; i++) mem[i] = 32'h5A;
    mem[9] = 32'h5B;
    scan(1'b0, 5'd0, 32'h5A, 32'd16, 5, lat, rv, fb);
`ifdef MEMCHECK_EARLY_EXIT_EN
    chk("restart_latency", 32'(lat), 32'd14);
    chk("restart_rv", rv, 32'd9);
`else
    chk("restart_latency", 32'(lat), 32'd19);
    chk("restart_rv", rv, 32'd15);
`endif
    chk("restart_first_bad", 32'(fb), 32'd9);

    // Reset during ISSUE aborts the scan with no finish pulse
    for (int i = 0; i < 20; i++) mem[i] = 32'hA5;
    @(negedge clk);
    m = 5'd0; c = 32'hA5; n = 32'd20; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("midscan_addr", 32'(addr_a), 32'd4);
    chk("midscan_rv", rv_a, 32'd3);
    reset = 1'b0;
    #1;
    chk("abort_finish", 32'(fin_a), 32'h0);
    chk("abort_rv", rv_a, 32'h0);
    chk("abort_first_bad", 32'(fb_a), 32'h1F);
    chk("abort_addr", 32'(addr_a), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    fin_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (fin_a === 1'b1) fin_seen = 1'b1;
    end
    chk("abort_no_finish", 32'(fin_seen), 32'h0);
    scan(1'b0, 5'd0, 32'hA5, 32'd20, 0, lat, rv, fb);
    chk("after_abort_latency", 32'(lat), 32'd23);
    chk("after_abort_rv", rv, 32'd20);
    chk("after_abort_first_bad", 32'(fb), 32'h1F);

    // Fill check at RD_LAT=3
    for (int i = 0; i < 8; i++) mem[i] = 32'hA5;
    scan(1'b1, 5'd0, 32'hA5, 32'd8, 0, lat, rv, fb);
    chk("lat3_latency", 32'(lat), 32'd13);
    chk("lat3_rv", rv, 32'd8);
    chk("lat3_first_bad", 32'(fb), 32'h1F);

    chk("write_port_idle", 32'(we_seen), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memcheck.md
Name: memcheck

Overview:
- Read-direction counterpart to the memset writer. Scans n consecutive words through the memory_controller interface, starting at base address m.
- Compares the low CMP_W bits of each word read back against the pattern c and reports the number of matching words.
- The first mismatching address is also reported.
- Sits beside memset on the same memory_controller port and is used to verify fills and to implement memcmp-style intrinsics.

Parameters:
- ADDR_W, `MEMORY_CONTROLLER_ADDR_SIZE, width of the address bus and of m.
- DATA_W, `MEMORY_CONTROLLER_DATA_SIZE, width of the read/write data buses.
- CMP_W, 8, number of low data bits compared against c.
- RD_LAT, 1, cycles from address presented to valid memory_controller_out (1..4).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a scan; sampled only in IDLE.
- m  in  ADDR_W  base address.
- c  in  32  compare pattern; only c[CMP_W-1:0] is used.
- n  in  32  word count.
- finish  out  1  one-cycle done pulse.
- return_val  out  32  count of matching words.
- first_bad  out  ADDR_W  address of the first mismatch; all-ones if none.
- memory_controller_address  out  ADDR_W  read address.
- memory_controller_write_enable  out  1  tied 0 in all states.
- memory_controller_in  out  DATA_W  tied 0.
- memory_controller_out  in  DATA_W  read data, valid RD_LAT cycles after its address.

Behaviour:
- Reset values (async assert, sync-safe deassert): state IDLE, finish 0, return_val 0, first_bad all-ones, address 0, write_enable 0, all internal counters and valid pipe 0.
- FSM states: IDLE, LATCH, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 → LATCH; captures m, c, n; clears return_val, first_bad and all counters.
  - start while not IDLE is ignored.
- LATCH:
  - n==0 → DONE directly; no memory access, return_val=0, first_bad all-ones.
  - otherwise → ISSUE.
- ISSUE:
  - Drives address = m + issued_cnt, one new address per cycle.
  - Pushes a 1 into an RD_LAT-deep valid shift pipe in parallel.
  - Stays in ISSUE while issued_cnt < n; → DRAIN in the cycle the n-th address is issued.
- Address arithmetic is modulo 2^ADDR_W. m=2^ADDR_W-1 with n=2 reads all-ones, then 0.
- DRAIN:
  - No new addresses; address holds its last value.
  - → DONE when the valid pipe is empty, i.e. exactly RD_LAT cycles after the last issue.
- Compare, every cycle the pipe tail is 1:
  - If memory_controller_out[CMP_W-1:0] == c[CMP_W-1:0], return_val increments.
  - Otherwise, first_bad is written only if it still holds all-ones. The address is taken from a matching RD_LAT-deep address pipe.
- DONE: finish=1 for exactly one cycle, then → IDLE. return_val and first_bad hold until the next accepted start.
- Latency with no early exit: start to finish = 1 (LATCH) + n (ISSUE) + RD_LAT (DRAIN) + 1 cycles.
- Counters are 32 bits. n up to 2^32-1 is legal; return_val never exceeds n.
- Reset asserted mid-scan aborts immediately to reset values. No finish pulse is generated.

Optional Feature:
- Macro: MEMCHECK_EARLY_EXIT_EN.
- When defined:
  - The first mismatch seen at the pipe tail forces → DRAIN, even if issuance is incomplete.
  - Reads still in flight are discarded, not compared.
  - return_val = matches strictly before the first mismatch.
  - Latency shortens accordingly.
- When undefined: all n words are always read and compared; this is the default behaviour described above.

Test Plan:
- Fill: memset(m=0, c=0xA5, n=8), then memcheck(m=0, c=0xA5, n=8) with RD_LAT=1 → finish on cycle 11 after start, return_val=8, first_bad=all-ones, write_enable never 1.
- Single corruption: memory[0..7]=0x3C except memory[5]=0x00; c=0x3C, n=8 → return_val=7, first_bad=5.
  - With MEMCHECK_EARLY_EXIT_EN defined → return_val=5, first_bad=5, finish earlier than the 11-cycle baseline.
- Zero count: n=0 → finish pulse 2 cycles after start, return_val=0, first_bad=all-ones, no address change.
- Wrap: ADDR_W=5, m=30, n=4 → addresses 30, 31, 0, 1 issued in order; return_val counts matches at those four locations.
- Robustness:
  - Pulse start again mid-scan → ignored; result is unchanged.
  - Assert reset during ISSUE at n=20 → finish=0, return_val=0, state IDLE. A following scan completes correctly.
  - Repeat the fill scenario with RD_LAT=3 → return_val=8, latency 13 cycles.
